// File: rtl/ssd_source_arbiter.sv
// ssd_source_arbiter
// Round-robin arbiter that shares the four-digit seven-segment display
// between up to N_SRC debug sources. Each source raises a request level.
// One source is granted at a time, and its value is registered onto num.
// The grant advances on any of these events:
//   - a dwell timeout (auto_mode),
//   - a debounced press of btn_next,
//   - withdrawal of the granted request.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   src_req    per-source request level
//   src_val    packed source values, source i at [i*NUM_W +: NUM_W]
//   btn_next   raw asynchronous push button (manual advance)
//   auto_mode  advance on dwell timeout
//   freeze     hold current grant (timeout and button ignored)
//   num        value for the display driver
//   src_sel    index of the granted source
//   src_grant  one-hot grant, zero when valid=0
//   valid      a source is granted
//
// Optional build macro SSD_LIVE_UPDATE_EN:
//   When defined, num tracks src_val[src_sel] every cycle while a source is granted.
//   When undefined, num is the snapshot taken in the grant cycle.
module ssd_source_arbiter #(
    parameter int unsigned N_SRC           = 4,
    parameter int unsigned NUM_W           = 13,
    parameter int unsigned DWELL_CYCLES    = 100000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    localparam int unsigned SEL_W          = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src_req,
    input  logic [N_SRC*NUM_W-1:0] src_val,
    input  logic                   btn_next,
    input  logic                   auto_mode,
    input  logic                   freeze,
    output logic [NUM_W-1:0]       num,
    output logic [SEL_W-1:0]       src_sel,
    output logic [N_SRC-1:0]       src_grant,
    output logic                   valid
);

    localparam int unsigned DW_W = $clog2(DWELL_CYCLES);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW_W-1:0] DwellMax = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DB_W-1:0] DebMax   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LastSrc = SEL_W'(N_SRC - 1);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;

    logic             sync1_q, sync2_q;
    logic             db_level_q, db_level_d;
    logic             db_prev_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             step;

    logic [NUM_W-1:0] val_arr [N_SRC];
    logic [SEL_W-1:0] ref_sel;
    logic [SEL_W-1:0] pick_idx;
    logic             any_req;
    logic             timeout;
    logic             trigger;

    for (genvar i = 0; i < N_SRC; i++) begin : g_val
        assign val_arr[i] = src_val[i*NUM_W +: NUM_W];
    end

    // ------------------------------------------------------------------
    // Button path
    // The debounced level flips only after DEBOUNCE_CYCLES consecutive
    // cycles of a differing synchronized level. Any bounce restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DebMax) begin
                db_level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // One pulse per rising edge of the debounced level.
    assign step = db_level_q & ~db_prev_q;

    // ------------------------------------------------------------------
    // Round-robin search
    // The search starts after ref_sel and wraps. ref_sel itself is visited
    // last, so it wins only if it is the sole requester.
    // ------------------------------------------------------------------
    assign ref_sel = (state_q == StShow) ? sel_q : last_q;
    assign any_req = |src_req;

    always_comb begin
        logic             found;
        logic [SEL_W-1:0] cand;
        found    = 1'b0;
        pick_idx = ref_sel;
        cand     = ref_sel;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            cand = (cand == LastSrc) ? '0 : cand + 1'b1;
            if (!found && src_req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    assign timeout = auto_mode & ~freeze & (dwell_q == DwellMax);
    // freeze never masks a withdrawn request
    assign trigger = timeout | (step & ~freeze) | ~src_req[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        num_d   = num_q;
        dwell_d = dwell_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StShow;
                    sel_d   = pick_idx;
                    num_d   = val_arr[pick_idx];
                    dwell_d = '0;
                end
            end
            StShow: begin
                if (trigger) begin
                    if (any_req) begin
                        // Regrant even if the pick is the current source.
                        sel_d   = pick_idx;
                        num_d   = val_arr[pick_idx];
                        dwell_d = '0;
                    end else begin
                        state_d = StIdle;
                        num_d   = '0;
                        last_d  = sel_q;
                        dwell_d = '0;
                    end
                end else begin
                    if (auto_mode && !freeze && dwell_q != DwellMax) begin
                        dwell_d = dwell_q + 1'b1;
                    end
`ifdef SSD_LIVE_UPDATE_EN
                    num_d = val_arr[sel_q];
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            last_q     <= LastSrc;
            num_q      <= '0;
            dwell_q    <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            num_q      <= num_d;
            dwell_q    <= dwell_d;
            sync1_q    <= btn_next;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign valid     = (state_q == StShow);
    assign src_sel   = sel_q;
    assign num       = num_q;
    assign src_grant = valid ? (N_SRC'(1) << sel_q) : '0;

endmodule

// File: tb/tb_ssd_source_arbiter.sv
// Randomized plus directed bench for ssd_source_arbiter. The bench uses a
// cycle-level reference model built from the arbitration rules.
module tb_ssd_source_arbiter;

    localparam int NS    = 4;
    localparam int NW    = 13;
    localparam int DWELL = 8;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NS-1:0]    src_req = '0;
    logic [NS*NW-1:0] src_val = '0;
    logic             btn_next = 1'b0;
    logic             auto_mode = 1'b0;
    logic             freeze = 1'b0;
    logic [NW-1:0]    num;
    logic [1:0]       src_sel;
    logic [NS-1:0]    src_grant;
    logic             valid;

    int total = 0;
    int bad   = 0;

    ssd_source_arbiter #(
        .N_SRC          (NS),
        .NUM_W          (NW),
        .DWELL_CYCLES   (DWELL),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_req  (src_req),
        .src_val  (src_val),
        .btn_next (btn_next),
        .auto_mode(auto_mode),
        .freeze   (freeze),
        .num      (num),
        .src_sel  (src_sel),
        .src_grant(src_grant),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid;
    int          m_sel, m_last, m_dwell;
    logic [NW-1:0] m_num;
    bit          m_b1, m_b2;     // button as seen one and two edges late
    bit          m_level;        // debounced level
    bit          m_level_prev;
    int          m_run;          // length of the current run of b2 != level

    function automatic logic [NW-1:0] val_of(int i);
        return src_val[i*NW +: NW];
    endfunction

    function automatic int rr_pick(int from);
        for (int k = 1; k <= NS; k++) begin
            if (src_req[(from + k) % NS]) return (from + k) % NS;
        end
        return from;
    endfunction

    task automatic model_edge();
        bit step, trig;
        int p;
        if (rst) begin
            m_valid = 0; m_sel = 0; m_last = NS - 1; m_dwell = 0; m_num = '0;
            m_b1 = 0; m_b2 = 0; m_level = 0; m_level_prev = 0; m_run = 0;
            return;
        end
        step = m_level && !m_level_prev;
        // arbitration uses pre-edge state
        if (!m_valid) begin
            if (src_req != 0) begin
                p = rr_pick(m_last);
                m_valid = 1; m_sel = p; m_num = val_of(p); m_dwell = 0;
            end
        end else begin
            trig = (auto_mode && !freeze && m_dwell == DWELL - 1) ||
                   (step && !freeze) || !src_req[m_sel];
            if (trig) begin
                if (src_req != 0) begin
                    p = rr_pick(m_sel);
                    m_sel = p; m_num = val_of(p); m_dwell = 0;
                end else begin
                    m_last = m_sel; m_valid = 0; m_num = '0; m_dwell = 0;
                end
            end else begin
                if (auto_mode && !freeze && m_dwell < DWELL - 1) m_dwell++;
`ifdef SSD_LIVE_UPDATE_EN
                m_num = val_of(m_sel);
`endif
            end
        end
        // button path
        m_level_prev = m_level;
        if (m_b2 != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = m_b2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_b2 = m_b1;
        m_b1 = btn_next;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("valid", {31'd0, valid}, {31'd0, m_valid});
        check_eq("num", {19'd0, num}, {19'd0, m_num});
        check_eq("grant", {28'd0, src_grant}, m_valid ? (32'd1 << m_sel) : 32'd0);
        if (m_valid) check_eq("sel", {30'd0, src_sel}, m_sel);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1; btn_next = 0; freeze = 0; auto_mode = 0; src_req = '0;
        tick();
        rst = 0;
    endtask

    task automatic set_val(int i, int v);
        src_val[i*NW +: NW] = NW'(v);
    endtask

    int exp_sel [4] = '{0, 1, 3, 0};
    int exp_num [4] = '{1234, 42, 8191, 1234};
    int changes, change_at, prev_sel;

    initial begin
        // idle after reset
        do_reset();
        check_eq("rst_valid", {31'd0, valid}, 0);
        check_eq("rst_sel", {30'd0, src_sel}, 0);
        check_eq("rst_grant", {28'd0, src_grant}, 0);
        check_eq("rst_num", {19'd0, num}, 0);
        for (int i = 0; i < 10; i++) tick();
        check_eq("idle_valid", {31'd0, valid}, 0);
        check_eq("idle_num", {19'd0, num}, 0);

        // auto-mode rotation 0,1,3,0 with 8-cycle dwell
        set_val(0, 1234); set_val(1, 42); set_val(2, 7); set_val(3, 8191);
        src_req = 4'b1011; auto_mode = 1;
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (t == 1 || t == 9 || t == 17 || t == 25) begin
                check_eq("rot_sel", {30'd0, src_sel}, exp_sel[(t - 1) / 8]);
                check_eq("rot_num", {19'd0, num}, exp_num[(t - 1) / 8]);
            end
            if (t == 8) check_eq("dwell_hold", {30'd0, src_sel}, 0);
        end

        // bouncing button, then held: one step
        do_reset();
        src_req = 4'b1011; auto_mode = 0;
        tick();
        check_eq("btn_start", {30'd0, src_sel}, 0);
        changes = 0; change_at = 0; prev_sel = src_sel;
        btn_next = 1; tick(); if (src_sel != prev_sel) changes++;
        prev_sel = src_sel;
        btn_next = 0; tick(); if (src_sel != prev_sel) changes++;
        prev_sel = src_sel;
        btn_next = 1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (src_sel != prev_sel) begin changes++; change_at = t; end
            prev_sel = src_sel;
        end
        check_eq("btn_steps", changes, 1);
        // step pulse 6 cycles after stable level, grant moves one edge later
        check_eq("btn_latency", change_at, 7);
        check_eq("btn_sel", {30'd0, src_sel}, 1);

        // freeze does not block withdrawal
        freeze = 1; btn_next = 0;
        src_req = 4'b1001; tick();
        check_eq("frz_drop_sel", {30'd0, src_sel}, 3);
        src_req = 4'b0000; tick();
        check_eq("frz_idle_valid", {31'd0, valid}, 0);
        check_eq("frz_idle_num", {19'd0, num}, 0);
        for (int i = 0; i < 8; i++) tick();
        freeze = 0;

        // step and dwell timeout in the same cycle: a single advance
        do_reset();
        src_req = 4'b0010; auto_mode = 1;
        tick();                         // grant source 1, dwell 0
        src_req = 4'b0110;
        tick();
        btn_next = 1;
        for (int t = 3; t <= 8; t++) tick();
        check_eq("coinc_pre", {30'd0, src_sel}, 1);
        tick();                         // timeout and step together
        check_eq("coinc_sel", {30'd0, src_sel}, 2);
        tick();
        check_eq("coinc_once", {30'd0, src_sel}, 2);
        btn_next = 0;

        // snapshot vs live update
        do_reset();
        auto_mode = 0; set_val(0, 100); src_req = 4'b0001;
        tick(); tick();
        set_val(0, 200);
        tick();
`ifdef SSD_LIVE_UPDATE_EN
        check_eq("snap_num", {19'd0, num}, 200);
`else
        check_eq("snap_num", {19'd0, num}, 100);
`endif
        tick();

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) src_req = NS'($urandom);
            for (int i = 0; i < NS; i++)
                if ($urandom_range(0, 3) == 0) set_val(i, $urandom);
            if ($urandom_range(0, 11) == 0) btn_next = ~btn_next;
            if ($urandom_range(0, 29) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 39) == 0) freeze = ~freeze;
            rst = ($urandom_range(0, 299) == 0);
            tick();
            rst = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssd_source_arbiter.md
Name: ssd_source_arbiter

Overview:
Shares the four-digit seven-segment display between up to N_SRC requesters, e.g. PC, ALU result, register read port and memory data. Each requester raises a request level. The arbiter grants one at a time, round-robin. It snapshots the granted value onto the display driver's 13-bit num input and advances on a dwell timeout, a debounced push-button step, or request withdrawal. It sits between the pipelined core's debug taps and the display driver in the FPGA top level.

Parameters:
N_SRC, 4, number of requesters (2..8); SEL_W = clog2(N_SRC), derived.
NUM_W, 13, width of each source value and of num.
DWELL_CYCLES, 100000000, auto-mode display time per source, in clk cycles (>=2).
DEBOUNCE_CYCLES, 1000000, stable-level time required on btn_next, in clk cycles (>=2).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
src_req  in  N_SRC  per-source request level.
src_val  in  N_SRC*NUM_W  packed values; source i is at bits [i*NUM_W +: NUM_W].
btn_next  in  1  raw, asynchronous push button; manual advance.
auto_mode  in  1  1 = advance on dwell timeout.
freeze  in  1  1 = hold current grant; ignore timeout and button.
num  out  NUM_W  value for the display driver.
src_sel  out  SEL_W  index of the granted source.
src_grant  out  N_SRC  one-hot grant; all zero when valid=0.
valid  out  1  a source is granted.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; num=0, src_sel=0, src_grant=0, valid=0.
  - dwell counter=0; last_sel=N_SRC-1, so the first grant searches from source 0.
  - Synchronizer flops and debounce state cleared.
  - Reset mid-dwell or mid-debounce aborts that activity with no step pulse.
- Button path:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level updates only after DEBOUNCE_CYCLES consecutive cycles of a synchronized level that differs from it. Any bounce restarts the count.
  - A rising edge of the debounced level produces a 1-cycle step pulse. A held button produces exactly one pulse.
- Round-robin pick:
  - Combinational search for the first i with src_req[i]=1, starting at (ref+1) mod N_SRC and wrapping.
  - ref=last_sel in IDLE and ref=src_sel in SHOW.
  - The current source is considered last, so it is re-picked only if it is the sole requester.
- IDLE:
  - If any src_req is set at edge t, then at edge t+1: state=SHOW, src_sel=pick, src_grant=1<<pick, valid=1, num=src_val[pick], dwell=0.
  - Grant latency is 1 cycle.
- SHOW, with trigger = (auto_mode & ~freeze & dwell==DWELL_CYCLES-1) | (step & ~freeze) | ~src_req[src_sel]:
  - No trigger: dwell increments only while auto_mode=1 & freeze=0. It holds otherwise and never wraps past DWELL_CYCLES-1.
  - Trigger with any request set: regrant to pick, re-snapshot num, dwell=0. This applies even when the pick equals the current source.
  - Trigger with no request set: state=IDLE, valid=0, src_grant=0, num=0, last_sel=src_sel.
- Simultaneous events (timeout+step, step+drop, timeout+drop) produce exactly one advance in that cycle.
- freeze does not block request withdrawal.
- num is constant between grants: it is the snapshot taken in the grant cycle.
- src_val of non-granted sources is ignored.
- Invariant: valid=1 implies src_grant is one-hot and equals 1<<src_sel.

Optional Feature:
Macro SSD_LIVE_UPDATE_EN.
- Defined: while valid=1, num <= src_val[src_sel] every cycle (1-cycle registered tracking). The snapshot rule is waived; all other behaviour is unchanged.
- Undefined: snapshot-only behaviour as specified above.

Test Plan:
- Reset, then src_req=4'b0000 for 10 cycles -> valid=0, num=0, src_grant=0 throughout.
- Run with DWELL_CYCLES=8. Set src_req=4'b1011, auto_mode=1, src_val[0]=1234, src_val[1]=42, src_val[3]=8191 -> grant sequence 0,1,3,0 with each grant held 8 cycles; num=1234, 42, 8191, 1234; grant asserted 1 cycle after the request.
- Run with DEBOUNCE_CYCLES=4 and auto_mode=0. Bounce btn_next 1-0-1 at 1-cycle spacing, then hold it at 1 for 10 cycles -> exactly one step, 4+2 cycles after the stable level begins; src_sel 0->1.
- With source 1 granted and freeze=1, drop src_req[1] -> next cycle src_sel=3. Then drop all requests -> next cycle state IDLE, valid=0, num=0.
- Set step and dwell expiry in the same cycle with src_req=4'b0110 -> a single advance, 1->2, not 1->2->1.
- Without SSD_LIVE_UPDATE_EN, change src_val[src_sel] mid-dwell from 100 to 200 -> num stays 100. With the macro defined -> num=200 one cycle later.
